// File: rtl/matmul_mmio_frontend_if.sv
// Peripheral-bus view of the matmul front end: word writes, registered reads.
// rd_en/wr_en are single-cycle requests with no backpressure; rvalid rises exactly one cycle after each rd_en.
interface matmul_mmio_frontend_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;

  modport master (output wr_en, rd_en, addr, wdata, input rdata, rvalid);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/matmul_mmio_frontend.sv
// MMIO front end for the systolic matmul array: operand register files, launch/wait/capture
// sequencing with timeout, result snapshot, sticky status and level interrupt.
module matmul_mmio_frontend #(
  parameter int ELEMENT_WIDTH  = 16,
  parameter int ROW_A          = 2,
  parameter int COL_A          = 2,
  parameter int ROW_B          = 2,
  parameter int COL_B          = 2,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  matmul_mmio_frontend_if.slave      bus,
  output logic                       irq,
  output logic [ELEMENT_WIDTH-1:0]   matrix_A [ROW_A][COL_A],
  output logic [ELEMENT_WIDTH-1:0]   matrix_B [ROW_B][COL_B],
  output logic                       initiateCompute,
  input  logic                       computeDone,
  input  logic [2*ELEMENT_WIDTH-1:0] resMatrix [ROW_A][COL_B],
  output logic [1:0]                 dbg_state
);
  localparam int CTRL_ADDR   = 'h00;
  localparam int STATUS_ADDR = 'h01;
  localparam int A_BASE      = 'h10;
  localparam int B_BASE      = 'h40;
  localparam int R_BASE      = 'h80;
  localparam int CNT_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW          = 2 * ELEMENT_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE} state_t;

  state_t state_q, state_d;

  logic [ELEMENT_WIDTH-1:0] a_q [ROW_A][COL_A];
  logic [ELEMENT_WIDTH-1:0] a_d [ROW_A][COL_A];
  logic [ELEMENT_WIDTH-1:0] b_q [ROW_B][COL_B];
  logic [ELEMENT_WIDTH-1:0] b_d [ROW_B][COL_B];
  logic [RW-1:0]            r_q [ROW_A][COL_B];
  logic [RW-1:0]            r_d [ROW_A][COL_B];
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     rvalid_q, rvalid_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     irq_en_q, irq_en_d;
  logic                     init_q, init_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic busy, ctrl_wr, start_wr, timeout_hit;
  logic unused_wdata;

  assign busy        = (state_q != S_IDLE);
  assign ctrl_wr     = bus.wr_en && (bus.addr == ADDR_WIDTH'(CTRL_ADDR));
  assign start_wr    = ctrl_wr && bus.wdata[0];
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign unused_wdata = ^bus.wdata[DATA_WIDTH-1:ELEMENT_WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_wr) state_d = S_LAUNCH;
      S_LAUNCH:  state_d = S_WAIT;
      S_WAIT: begin
        if (computeDone)      state_d = S_CAPTURE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    done_d   = done_q;
    err_d    = err_q;
    irq_en_d = irq_en_q;
    cnt_d    = cnt_q;
    // Clear applies before a dropped start, so clear+start while busy leaves err set.
    if (ctrl_wr) begin
      irq_en_d = bus.wdata[2];
      if (bus.wdata[1]) begin
        err_d = 1'b0;
        if (!busy) done_d = 1'b0;
      end
      if (bus.wdata[0]) begin
        if (busy) err_d  = 1'b1;
        else      done_d = 1'b0;
      end
    end
    if (bus.wr_en) begin
      for (int i = 0; i < ROW_A; i++)
        for (int j = 0; j < COL_A; j++)
          if (bus.addr == ADDR_WIDTH'(A_BASE + i*COL_A + j)) begin
            if (busy) err_d = 1'b1;
            else      a_d[i][j] = bus.wdata[ELEMENT_WIDTH-1:0];
          end
      for (int i = 0; i < ROW_B; i++)
        for (int j = 0; j < COL_B; j++)
          if (bus.addr == ADDR_WIDTH'(B_BASE + i*COL_B + j)) begin
            if (busy) err_d = 1'b1;
            else      b_d[i][j] = bus.wdata[ELEMENT_WIDTH-1:0];
          end
    end
    case (state_q)
      S_LAUNCH: cnt_d = '0;
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!computeDone && timeout_hit) err_d = 1'b1;
      end
      S_CAPTURE: begin
        r_d    = resMatrix;
        done_d = 1'b1;
      end
      default: ;
    endcase
    init_d = (state_d == S_LAUNCH);
  end

  // Read mux samples pre-write register values, so a same-cycle write+read returns old data.
  always_comb begin
    rdata_d  = '0;
    rvalid_d = bus.rd_en;
    if (bus.rd_en) begin
      if (bus.addr == ADDR_WIDTH'(STATUS_ADDR))
        rdata_d = DATA_WIDTH'({irq_en_q, err_q, done_q, busy});
      for (int i = 0; i < ROW_A; i++)
        for (int j = 0; j < COL_A; j++)
          if (bus.addr == ADDR_WIDTH'(A_BASE + i*COL_A + j)) rdata_d = DATA_WIDTH'(a_q[i][j]);
      for (int i = 0; i < ROW_B; i++)
        for (int j = 0; j < COL_B; j++)
          if (bus.addr == ADDR_WIDTH'(B_BASE + i*COL_B + j)) rdata_d = DATA_WIDTH'(b_q[i][j]);
      for (int i = 0; i < ROW_A; i++)
        for (int j = 0; j < COL_B; j++)
          if (bus.addr == ADDR_WIDTH'(R_BASE + i*COL_B + j)) rdata_d = DATA_WIDTH'(r_q[i][j]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '{default: '0};
      b_q      <= '{default: '0};
      r_q      <= '{default: '0};
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= 1'b0;
      init_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_en_q <= irq_en_d;
      init_q   <= init_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.rvalid      = rvalid_q;
  assign irq             = done_q & irq_en_q;
  assign initiateCompute = init_q;
  assign matrix_A        = a_q;
  assign matrix_B        = b_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_matmul_mmio_frontend.sv
// Directed + randomized bench for matmul_mmio_frontend with a behavioural array model
// and a matrix-product reference computed from the operands the bench wrote.
module tb_matmul_mmio_frontend;
  localparam int EW = 16, RA = 2, CA = 2, RB = 2, CB = 2;
  localparam int AW = 8, DW = 32, TO = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matmul_mmio_frontend_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic            irq, initiate, compute_done;
  logic [1:0]      dbg_state;
  logic [EW-1:0]   mat_a [RA][CA];
  logic [EW-1:0]   mat_b [RB][CB];
  logic [2*EW-1:0] res_m [RA][CB];

  matmul_mmio_frontend #(
    .ELEMENT_WIDTH(EW), .ROW_A(RA), .COL_A(CA), .ROW_B(RB), .COL_B(CB),
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bus), .irq(irq),
    .matrix_A(mat_a), .matrix_B(mat_b), .initiateCompute(initiate),
    .computeDone(compute_done), .resMatrix(res_m), .dbg_state(dbg_state)
  );

  // behavioural systolic array: fixed latency after the start pulse, optionally never finishes
  int arr_cnt = 0;
  int array_lat = 3;
  bit array_enable = 1'b1;

  function automatic logic [2*EW-1:0] array_dot(input int i, input int j);
    logic [2*EW-1:0] acc = '0;
    for (int k = 0; k < CA; k++) acc += (2*EW)'(mat_a[i][k]) * (2*EW)'(mat_b[k][j]);
    return acc;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      compute_done <= 1'b0;
      arr_cnt      <= 0;
      res_m        <= '{default: '0};
    end else if (initiate) begin
      compute_done <= 1'b0;
      arr_cnt      <= array_lat;
    end else if (arr_cnt > 0) begin
      arr_cnt <= arr_cnt - 1;
      if (arr_cnt == 1 && array_enable) begin
        compute_done <= 1'b1;
        for (int i = 0; i < RA; i++)
          for (int j = 0; j < CB; j++) res_m[i][j] <= array_dot(i, j);
      end
    end
  end

  // start-pulse monitor
  int pulse_cnt = 0, run_len = 0, max_run = 0;
  always @(negedge clk) begin
    if (initiate) begin
      if (run_len == 0) pulse_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  // scoreboard
  int tests = 0, failed = 0;
  logic [DW-1:0] exp_q[$];
  logic [EW-1:0] sa [RA][CA];
  logic [EW-1:0] sb [RB][CB];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
    @(negedge clk);
    bus.rd_en = 1'b1; bus.addr = a;
    @(posedge clk); #1;
    d = bus.rdata; v = bus.rvalid;
    bus.rd_en = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    logic [DW-1:0] d; logic v;
    bus_read(a, d, v);
    check(tag, d, exp);
  endtask

  task automatic load_operands();
    for (int i = 0; i < RA; i++)
      for (int j = 0; j < CA; j++) bus_write(AW'('h10 + i*CA + j), DW'(sa[i][j]));
    for (int i = 0; i < RB; i++)
      for (int j = 0; j < CB; j++) bus_write(AW'('h40 + i*CB + j), DW'(sb[i][j]));
  endtask

  // reference: plain matrix product of what the bench wrote, truncated to result width
  task automatic push_expected();
    for (int i = 0; i < RA; i++)
      for (int j = 0; j < CB; j++) begin
        longint unsigned acc = 0;
        for (int k = 0; k < CA; k++) acc += longint'(sa[i][k]) * longint'(sb[k][j]);
        exp_q.push_back(DW'(acc % (64'd1 << (2*EW))));
      end
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < RA; i++)
      for (int j = 0; j < CB; j++)
        read_check($sformatf("%s_r%0d%0d", tag, i, j), AW'('h80 + i*CB + j), exp_q.pop_front());
  endtask

  task automatic wait_idle(input string tag);
    logic [DW-1:0] st; logic v;
    st = '1;
    for (int n = 0; n < 300 && st[0] !== 1'b0; n++) bus_read(8'h01, st, v);
    check({tag, "_poll_busy"}, DW'(st[0]), '0);
  endtask

  task automatic set_matrices(input logic [EW-1:0] a00, a01, a10, a11, b00, b01, b10, b11);
    sa[0][0] = a00; sa[0][1] = a01; sa[1][0] = a10; sa[1][1] = a11;
    sb[0][0] = b00; sb[0][1] = b01; sb[1][0] = b10; sb[1][1] = b11;
  endtask

  initial begin
    logic [DW-1:0] d; logic v;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;

    // reset state
    #12;
    check("rst_rdata", bus.rdata, '0);
    check("rst_rvalid", DW'(bus.rvalid), '0);
    check("rst_init", DW'(initiate), '0);
    check("rst_irq", DW'(irq), '0);
    @(negedge clk); rst_n = 1'b1;
    read_check("rst_status", 8'h01, 32'h0);
    read_check("rst_r00", 8'h80, 32'h0);

    // 2x2 product
    set_matrices(1, 2, 3, 4, 5, 6, 7, 8);
    load_operands();
    read_check("rb_a01", 8'h11, 32'd2);
    read_check("rb_b11", 8'h43, 32'd8);
    check("port_b10", DW'(mat_b[1][0]), 32'd7);
    bus_write(8'h00, 32'h1);
    wait_idle("mm");
    read_check("mm_status", 8'h01, 32'h2);
    push_expected();
    check_results("mm");
    check("mm_pulses", DW'(pulse_cnt), 32'd1);
    check("mm_pulse_width", DW'(max_run), 32'd1);

    // write protection while busy
    array_lat = 6;
    bus_write(8'h00, 32'h1);
    bus_write(8'h10, 32'd99);
    wait_idle("wp");
    read_check("wp_status", 8'h01, 32'h6);
    push_expected();
    check_results("wp");
    read_check("wp_a00", 8'h10, 32'd1);
    bus_write(8'h00, 32'h2);
    read_check("wp_clr_status", 8'h01, 32'h0);

    // timeout: the array never answers
    array_enable = 1'b0;
    bus_write(8'h00, 32'h1);
    repeat (TO - 1) @(negedge clk);
    read_check("to_last_wait", 8'h01, 32'h1);
    read_check("to_status", 8'h01, 32'h4);
    push_expected();
    check_results("to");

    // clear and start in one write
    array_enable = 1'b1;
    array_lat = 2;
    bus_write(8'h00, 32'h3);
    wait_idle("cs");
    read_check("cs_status", 8'h01, 32'h2);

    // irq and readback
    bus_write(8'h00, 32'h4);
    set_matrices(16'hFFFF, 0, 0, 0, 16'hFFFF, 0, 0, 0);
    load_operands();
    bus_write(8'h00, 32'h5);
    wait_idle("irq");
    check("irq_level", DW'(irq), 32'h1);
    read_check("irq_status", 8'h01, 32'hA);
    @(negedge clk); bus.rd_en = 1'b1; bus.addr = 8'h80;
    @(posedge clk); #1;
    check("b2b_rv0", DW'(bus.rvalid), 32'h1);
    check("b2b_d0", bus.rdata, 32'hFFFE0001);
    @(negedge clk); bus.addr = 8'h81;
    @(posedge clk); #1;
    check("b2b_rv1", DW'(bus.rvalid), 32'h1);
    check("b2b_d1", bus.rdata, 32'h0);
    @(negedge clk); bus.rd_en = 1'b0;
    @(posedge clk); #1;
    check("b2b_rv_drop", DW'(bus.rvalid), 32'h0);
    read_check("unmapped_30", 8'h30, 32'h0);
    read_check("unmapped_84", 8'h84, 32'h0);
    @(negedge clk); bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.addr = 8'h10; bus.wdata = 32'h1234;
    @(posedge clk); #1;
    check("rw_same_cycle", bus.rdata, 32'hFFFF);
    @(negedge clk); bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    read_check("rw_after", 8'h10, 32'h1234);
    bus_write(8'h00, 32'h6);
    check("irq_cleared", DW'(irq), 32'h0);
    bus_write(8'h00, 32'h0);
    read_check("irq_en_off", 8'h01, 32'h0);

    // randomized products
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < RA; i++)
        for (int j = 0; j < CA; j++) sa[i][j] = EW'($urandom_range(0, 16'hFFFF));
      for (int i = 0; i < RB; i++)
        for (int j = 0; j < CB; j++) sb[i][j] = EW'($urandom_range(0, 16'hFFFF));
      array_lat = $urandom_range(1, 12);
      load_operands();
      check($sformatf("rnd%0d_port_a11", r), DW'(mat_a[1][1]), DW'(sa[1][1]));
      bus_write(8'h00, 32'h1);
      wait_idle($sformatf("rnd%0d", r));
      read_check($sformatf("rnd%0d_status", r), 8'h01, 32'h2);
      push_expected();
      check_results($sformatf("rnd%0d", r));
    end

    // asynchronous reset during WAIT, with a read in flight
    array_lat = 30;
    bus_write(8'h00, 32'h1);
    repeat (4) @(negedge clk);
    bus.rd_en = 1'b1; bus.addr = 8'h10;
    @(posedge clk); #1;
    check("mr_rvalid_pre", DW'(bus.rvalid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mr_rvalid", DW'(bus.rvalid), 32'h0);
    check("mr_rdata", bus.rdata, 32'h0);
    check("mr_init", DW'(initiate), 32'h0);
    check("mr_a00", DW'(mat_a[0][0]), 32'h0);
    bus.rd_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    read_check("mr_status", 8'h01, 32'h0);
    set_matrices(0, 0, 0, 0, 0, 0, 0, 0);
    push_expected();
    check_results("mr");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
